// File: rtl/circuit3_2_pipe.sv
// Two-stage pipelined K = A&B, L = ~(B&C), Z = K^L across WIDTH lanes, with
// valid/ready handshakes and a built-in exhaustive sweep that counts ones in z.
module circuit3_2_pipe #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(8*WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] l,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    ones_count
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t           state;
    logic             v1, v2;
    logic [WIDTH-1:0] k1, l1;
    logic [2:0]       idx;
    logic             en1, en2;
    logic             src_valid;
    logic [WIDTH-1:0] src_a, src_b, src_c;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = (state == S_IDLE) && en1;
    assign out_valid = v2;

    // External inputs feed the pipe only in IDLE; the sweep replicates idx bits across lanes.
    always_comb begin
        src_valid = 1'b0;
        src_a     = a;
        src_b     = b;
        src_c     = c;
        if (state == S_IDLE) begin
            src_valid = in_valid;
        end else if (state == S_SWEEP) begin
            src_valid = 1'b1;
            src_a     = {WIDTH{idx[2]}};
            src_b     = {WIDTH{idx[1]}};
            src_c     = {WIDTH{idx[0]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            k1 <= '0;
            l1 <= '0;
            k  <= '0;
            l  <= '0;
            z  <= '0;
        end else begin
            if (en1) begin
                v1 <= src_valid;
                if (src_valid) begin
                    k1 <= src_a & src_b;
                    l1 <= ~(src_b & src_c);
                end
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    k <= k1;
                    l <= l1;
                    z <= k1 ^ l1;
                end
            end
        end
    end

    // A start coinciding with an input acceptance is dropped: the pipe would not be empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            ones_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (busy && v2 && out_ready) ones_count <= ones_count + popcount(z);
            case (state)
                S_IDLE: begin
                    if (start && mode && !v1 && !v2 && !in_valid) begin
                        state      <= S_SWEEP;
                        idx        <= '0;
                        ones_count <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (en1) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!v1 && !v2) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_circuit3_2_pipe.sv
// Directed, table-driven bench for circuit3_2_pipe: pass-through latency,
// backpressure, sweep counting, start filtering and asynchronous reset.
module tb_circuit3_2_pipe;

    localparam int W  = 4;
    localparam int CW = $clog2(8*W+1);

    logic          clk = 1'b0;
    logic          rst, mode, start, in_valid, out_ready;
    logic          in_ready, out_valid, busy, done;
    logic [W-1:0]  a, b, c, z, k, l;
    logic [CW-1:0] ones_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a, b, c, k, l, z;
    } vec_t;
    vec_t vec [13];

    circuit3_2_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .k(k), .l(l),
        .busy(busy), .done(done), .ones_count(ones_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        a = vec[i].a;
        b = vec[i].b;
        c = vec[i].c;
    endtask

    // rmode: 0 = out_ready always high, 1 = low for 5 cycles then high, 2 = toggling
    task automatic applyStimulus(input int first, input int count, input int rmode);
        int sent = 0, recv = 0, cyc = 0, stall_acc = 0;
        while (recv < count && cyc < 200) begin
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc >= 5) : cyc[0];
            if (sent < count) begin
                drive(first + sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                sent++;
                if (rmode == 1 && cyc < 5) stall_acc++;
            end
            if (rmode == 1 && cyc >= 2 && cyc < 5) begin
                checkOutput("stall_in_ready", in_ready, 0);
                checkOutput("stall_z_hold", z, vec[first].z);
            end
            if (out_valid && out_ready) begin
                checkOutput("hs_k", k, vec[first + recv].k);
                checkOutput("hs_l", l, vec[first + recv].l);
                checkOutput("hs_z", z, vec[first + recv].z);
                recv++;
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("hs_recv_count", recv, count);
        if (rmode == 1) checkOutput("stall_accepts", stall_acc, 2);
    endtask

    task automatic runSweep(input int rmode);
        int n_out = 0, n_done = 0, cyc = 0;
        bit seen_done = 0;
        mode = 1'b1; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick;
        start = 1'b0; mode = 1'b0;
        checkOutput("sweep_busy_rise", busy, 1);
        while (cyc < 60 && !(seen_done && !busy)) begin
            out_ready = (rmode == 0) ? 1'b1 : cyc[0];
            in_valid  = 1'b1;
            drive(0);
            #1;
            if (cyc == 2) checkOutput("sweep_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (n_out < 8) checkOutput("sweep_z", z, vec[1 + n_out].z);
                n_out++;
            end
            tick;
            if (done) begin
                n_done++;
                seen_done = 1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("sweep_outputs", n_out, 8);
        checkOutput("sweep_done_pulses", n_done, 1);
        checkOutput("sweep_ones_count", ones_count, 6*W);
        checkOutput("sweep_busy_fall", busy, 0);
    endtask

    initial begin
        vec[0]  = '{4'hC, 4'hA, 4'h6, 4'h8, 4'hD, 4'h5};
        vec[1]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
        vec[2]  = '{4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF};
        vec[3]  = '{4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
        vec[4]  = '{4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        vec[5]  = '{4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
        vec[6]  = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF};
        vec[7]  = '{4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0};
        vec[8]  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF};
        vec[9]  = '{4'hF, 4'h5, 4'h3, 4'h5, 4'hE, 4'hB};
        vec[10] = '{4'h3, 4'hF, 4'hA, 4'h3, 4'h5, 4'h6};
        vec[11] = '{4'h9, 4'h6, 4'hC, 4'h0, 4'hB, 4'hB};
        vec[12] = '{4'h5, 4'h3, 4'hE, 4'h1, 4'hD, 4'hC};

        rst = 1'b1; mode = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_z", z, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ones_count", ones_count, 0);
        #3 rst = 1'b0;
        tick;

        // Back-to-back pass-through: first vector plus the 8 exhaustive combinations
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) begin
                drive(i);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            #1;
            if (i < 9) checkOutput("pass_in_ready", in_ready, 1);
            tick;
            if (i >= 1) begin
                checkOutput("pass_out_valid", out_valid, 1);
                checkOutput("pass_k", k, vec[i-1].k);
                checkOutput("pass_l", l, vec[i-1].l);
                checkOutput("pass_z", z, vec[i-1].z);
            end
        end
        tick;
        checkOutput("pass_drained", out_valid, 0);

        applyStimulus(9, 4, 1);
        applyStimulus(9, 4, 2);
        tick;

        runSweep(0);
        tick;
        runSweep(2);
        tick;

        // Start with mode=0 is ignored
        mode = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        checkOutput("start_mode0_busy", busy, 0);

        // Start in the same cycle as an input acceptance is ignored
        mode = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(0);
        tick;
        start = 1'b0; mode = 1'b0; in_valid = 1'b0;
        checkOutput("start_same_cycle_busy", busy, 0);
        tick;
        checkOutput("start_same_cycle_out", z, vec[0].z);
        tick;

        // Start while stage 2 holds a vector is ignored
        out_ready = 1'b0; in_valid = 1'b1;
        drive(9);
        tick;
        in_valid = 1'b0;
        tick;
        mode = 1'b1; start = 1'b1;
        tick;
        start = 1'b0; mode = 1'b0;
        checkOutput("start_v2_busy", busy, 0);
        out_ready = 1'b1;
        #1;
        checkOutput("start_v2_out_valid", out_valid, 1);
        checkOutput("start_v2_z", z, vec[9].z);
        tick;
        tick;

        // Asynchronous reset at idx=4 of a sweep
        mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        tick;
        start = 1'b0; mode = 1'b0;
        repeat (4) tick;
        checkOutput("midsweep_ones_count", ones_count, 2*W);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_z", z, 0);
        checkOutput("arst_k", k, 0);
        checkOutput("arst_l", l, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        checkOutput("arst_ones_count", ones_count, 0);
        checkOutput("arst_in_ready", in_ready, 1);
        #2 rst = 1'b0;
        begin
            int n_done = 0, n_busy = 0, n_ov = 0;
            for (int i = 0; i < 15; i++) begin
                tick;
                if (done) n_done++;
                if (busy) n_busy++;
                if (out_valid) n_ov++;
            end
            checkOutput("post_rst_done", n_done, 0);
            checkOutput("post_rst_busy", n_busy, 0);
            checkOutput("post_rst_out_valid", n_ov, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
